// File: rtl/sid_pkg.sv
// Shared constants and the sequencer state encoding for the SID bus block.
// Contents:
//   SID_ADDR_W   - SID register address width
//   SID_DATA_W   - SID register data width
//   NUM_SID_REGS - number of writable SID registers (0x00-0x18)
//   seq_state_t  - sequencer FSM states
package sid_pkg;

  localparam int SID_ADDR_W   = 5;
  localparam int SID_DATA_W   = 8;
  localparam int NUM_SID_REGS = 25;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_FETCH   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_SETUP   = 3'd4,
    ST_STROBE  = 3'd5,
    ST_NEXT    = 3'd6,
    ST_DONE    = 3'd7
  } seq_state_t;

endpackage

// File: rtl/sid_clk_gen.sv
// Free-running phi2 generator for the SID chip.
// Ports:
//   i_clk, i_rst_n - system clock, asynchronous active-low reset
//   o_sid_clk      - phi2, 50% duty, period CLK_DIV system clocks
//   o_rise_tick    - high in the clk cycle whose closing edge drives sid_clk 0->1
//   o_fall_tick    - high in the clk cycle whose closing edge drives sid_clk 1->0
module sid_clk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sid_clk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sid_clk;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(HALF - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_sid_clk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt     <= '0;
      r_sid_clk <= ~r_sid_clk;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Ticks lead the pin by one cycle on purpose: a register that updates on a
  // tick changes on the very edge that flips sid_clk, so bus signals keyed on
  // the ticks stay in exact phase with phi2.
  assign o_sid_clk   = r_sid_clk;
  assign o_rise_tick = w_wrap & ~r_sid_clk;
  assign o_fall_tick = w_wrap &  r_sid_clk;

endmodule

// File: rtl/sid_bus_sequencer.sv
// Copies changed registers from the SPI-filled register RAM onto the SID bus.
// On each frame the RAM is scanned 0..NUM_REGS-1; every entry that differs
// from the shadow of the last written value (or was never written, or the
// frame was forced) produces one phi2-aligned SID write cycle.
// Ports:
//   i_clk, i_rst_n  - system clock, asynchronous active-low reset
//   i_frame_rdy     - 1-cycle pulse: a complete frame is in RAM
//   i_force_all     - sampled at frame start: write every register
//   o_ram_addr      - RAM read address; i_ram_data valid 1 clk later
//   o_busy          - high outside IDLE
//   o_frame_done    - 1-cycle pulse at end of frame
//   o_overrun       - 1-cycle pulse: frame_rdy while one already pending
//   o_sid_clk, o_sid_addr, o_sid_data, o_sid_cs, o_sid_rw, o_sid_rst - SID pins
//   o_dbg_state     - current sequencer state (seq_state_t encoding)
// Frame request protocol: i_frame_rdy has no ready. In IDLE it starts a frame
// at once; otherwise it sets a single pending flag that is served right after
// DONE. A request arriving while that flag is already set is merged into it
// and reported on o_overrun.
module sid_bus_sequencer
  import sid_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int NUM_REGS    = NUM_SID_REGS,
  parameter int RST_PERIODS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_rdy,
  input  logic                  i_force_all,
  output logic [SID_ADDR_W-1:0] o_ram_addr,
  input  logic [SID_DATA_W-1:0] i_ram_data,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_overrun,
  output logic                  o_sid_clk,
  output logic [SID_ADDR_W-1:0] o_sid_addr,
  output logic [SID_DATA_W-1:0] o_sid_data,
  output logic                  o_sid_cs,
  output logic                  o_sid_rw,
  output logic                  o_sid_rst,
  output logic [2:0]            o_dbg_state
);

  localparam int RCW = $clog2(RST_PERIODS + 1);

  seq_state_t            r_state, w_next;
  logic [SID_ADDR_W-1:0] r_idx;
  logic                  r_pending, r_force, r_overrun;
  logic [RCW-1:0]        r_rst_cnt;
  logic [SID_DATA_W-1:0] r_wdata;
  logic [SID_DATA_W-1:0] r_shadow [NUM_REGS];
  logic [NUM_REGS-1:0]   r_valid;
  logic [SID_ADDR_W-1:0] r_sid_addr;
  logic [SID_DATA_W-1:0] r_sid_data;
  logic                  r_sid_cs, r_sid_rw, r_sid_rst;

  logic w_rise, w_fall, w_last_reset, w_last_reg, w_start, w_need_write, w_commit;

  sid_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_sid_clk   (o_sid_clk),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  assign w_last_reset = w_fall && (r_rst_cnt == RCW'(RST_PERIODS - 1));
  assign w_last_reg   = (r_idx == SID_ADDR_W'(NUM_REGS - 1));
  assign w_start      = (r_state == ST_IDLE) && (i_frame_rdy || r_pending);
  assign w_need_write = r_force || !r_valid[r_idx] || (i_ram_data != r_shadow[r_idx]);
  // STROBE is entered on a fall tick, so the first tick seen with cs already
  // low is the fall that closes the high phase.
  assign w_commit     = (r_state == ST_STROBE) && w_fall && !r_sid_cs;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_RESET;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:   if (w_last_reset) w_next = ST_IDLE;
      ST_IDLE:    if (w_start) w_next = ST_FETCH;
      ST_FETCH:   w_next = ST_COMPARE;
      ST_COMPARE: w_next = w_need_write ? ST_SETUP : ST_NEXT;
      ST_SETUP:   if (w_fall) w_next = ST_STROBE;
      ST_STROBE:  if (w_commit) w_next = ST_NEXT;
      ST_NEXT:    w_next = w_last_reg ? ST_DONE : ST_FETCH;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_RESET;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy       = (r_state != ST_IDLE);
    o_frame_done = (r_state == ST_DONE);
    o_dbg_state  = r_state;
  end

  // Datapath and SID bus registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_force    <= 1'b0;
      r_overrun  <= 1'b0;
      r_rst_cnt  <= '0;
      r_wdata    <= '0;
      r_valid    <= '0;
      r_sid_addr <= '0;
      r_sid_data <= '0;
      r_sid_cs   <= 1'b1;
      r_sid_rw   <= 1'b1;
      r_sid_rst  <= 1'b0;
    end else begin
      r_overrun <= i_frame_rdy && r_pending;
      // IDLE consumes any request (new pulse and/or pending) in one go.
      if (r_state == ST_IDLE)  r_pending <= 1'b0;
      else if (i_frame_rdy)    r_pending <= 1'b1;

      case (r_state)
        ST_RESET: if (w_fall) begin
          if (w_last_reset) r_sid_rst <= 1'b1;
          else              r_rst_cnt <= r_rst_cnt + RCW'(1);
        end
        ST_IDLE: if (w_start) begin
          r_idx   <= '0;
          r_force <= i_force_all;
        end
        ST_COMPARE: r_wdata <= i_ram_data;
        ST_SETUP: if (w_fall) begin
          r_sid_addr <= r_idx;
          r_sid_data <= r_wdata;
          r_sid_rw   <= 1'b0;
        end
        ST_STROBE: begin
          if (w_rise && r_sid_cs) r_sid_cs <= 1'b0;
          if (w_commit) begin
            r_sid_cs       <= 1'b1;
            r_sid_rw       <= 1'b1;
            r_valid[r_idx] <= 1'b1;
          end
        end
        ST_NEXT: if (!w_last_reg) r_idx <= r_idx + SID_ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Shadow data needs no reset: r_valid gates every use of it.
  always_ff @(posedge i_clk) begin
    if (w_commit) r_shadow[r_idx] <= r_sid_data;
  end

  assign o_ram_addr = r_idx;
  assign o_overrun  = r_overrun;
  assign o_sid_addr = r_sid_addr;
  assign o_sid_data = r_sid_data;
  assign o_sid_cs   = r_sid_cs;
  assign o_sid_rw   = r_sid_rw;
  assign o_sid_rst  = r_sid_rst;

endmodule

// File: tb/tb_sid_bus_sequencer.sv
module tb_sid_bus_sequencer;

  localparam int NREG = 25;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       frame_rdy = 1'b0, force_all = 1'b0;
  logic [4:0] ram_addr, sid_addr;
  logic [7:0] ram_q, sid_data;
  logic       busy, frame_done, overrun, sid_clk, sid_cs, sid_rw, sid_rst;
  logic [2:0] dbg_state;

  sid_bus_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_rdy(frame_rdy), .i_force_all(force_all),
    .o_ram_addr(ram_addr), .i_ram_data(ram_q), .o_busy(busy), .o_frame_done(frame_done),
    .o_overrun(overrun), .o_sid_clk(sid_clk), .o_sid_addr(sid_addr), .o_sid_data(sid_data),
    .o_sid_cs(sid_cs), .o_sid_rw(sid_rw), .o_sid_rst(sid_rst), .o_dbg_state(dbg_state)
  );

  // Register RAM: synchronous read, data valid one clk after the address.
  logic [7:0] ram [32];
  always @(posedge clk) ram_q <= ram[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected SID writes as {addr, data}, in bus order.
  logic [12:0] exp_q[$];
  logic [7:0]  mdl_shadow [NREG];
  bit          mdl_valid [NREG];

  task automatic model_frame(input bit frc, output int nwr);
    nwr = 0;
    for (int i = 0; i < NREG; i++) begin
      if (frc || !mdl_valid[i] || ram[i] != mdl_shadow[i]) begin
        exp_q.push_back({5'(i), ram[i]});
        mdl_shadow[i] = ram[i];
        mdl_valid[i]  = 1'b1;
        nwr++;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NREG; i++) mdl_valid[i] = 1'b0;
  endtask

  // ---------------- bus monitor ----------------
  int   done_cnt = 0, done_cyc = 0, ovr_cnt = 0, writes = 0, cs_falls = 0;
  logic cs_prev = 1'b1, prev_done = 1'b0, low_ok;
  int   low_cnt = 0;
  logic [4:0] cap_addr;
  logic [7:0] cap_data;
  logic [12:0] exp_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      cs_prev = 1'b1; low_cnt = 0; prev_done = 1'b0;
    end else begin
      if (frame_done) begin
        chk("frame_done_width", prev_done, 1'b0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = frame_done;
      if (overrun) ovr_cnt++;
      if (cs_prev && !sid_cs) begin
        cap_addr = sid_addr; cap_data = sid_data;
        low_cnt = 1; low_ok = sid_clk && !sid_rw;
        cs_falls++;
      end else if (!cs_prev && !sid_cs) begin
        low_cnt++;
        if (!(sid_clk && !sid_rw && sid_addr == cap_addr && sid_data == cap_data)) low_ok = 1'b0;
      end else if (!cs_prev && sid_cs) begin
        writes++;
        chk("cs_low_clks", low_cnt, 8);
        chk("cs_in_high_phase", low_ok, 1'b1);
        chk("rw_release", sid_rw, 1'b1);
        chk("addr_hold", sid_addr, cap_addr);
        chk("addr_range", cap_addr <= 5'd24, 1'b1);
        chk("write_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          chk("write_addr_data", {cap_addr, cap_data}, exp_w);
        end
      end
      cs_prev = sid_cs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_frame(input logic frc);
    @(posedge clk); #1 frame_rdy = 1'b1; force_all = frc;
    @(posedge clk); #1 frame_rdy = 1'b0; force_all = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk); n++;
    end
    chk("frame_done_timeout", done_cnt >= target, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string tag, input bit frc);
    int nexp, w0, d0;
    model_frame(frc, nexp);
    w0 = writes; d0 = done_cnt;
    repeat ($urandom_range(0, 20)) @(posedge clk);
    pulse_frame(frc);
    wait_done(d0 + 1, 2500);
    chk({tag, "_writes"}, writes - w0, nexp);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, d0, start, nexp, nexp2, ok;
    for (int i = 0; i < 32; i++) ram[i] = 8'(i);
    model_reset();

    // Reset values
    #23;
    chk("rst_sid_clk", sid_clk, 1'b0);
    chk("rst_sid_cs", sid_cs, 1'b1);
    chk("rst_sid_rw", sid_rw, 1'b1);
    chk("rst_sid_rst", sid_rst, 1'b0);
    chk("rst_sid_addr", sid_addr, 5'd0);
    chk("rst_sid_data", sid_data, 8'd0);
    chk("rst_ram_addr", ram_addr, 5'd0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);

    // 1. Reset sequence: 16 sid_clk periods = 256 clk
    rst_n = 1'b1;
    repeat (250) @(posedge clk);
    #1 chk("sid_rst_held", sid_rst, 1'b0);
    chk("busy_in_reset", busy, 1'b1);
    repeat (10) @(posedge clk);
    #1 chk("sid_rst_released", sid_rst, 1'b1);
    chk("busy_after_reset", busy, 1'b0);
    chk("no_cs_in_reset", cs_falls, 0);

    // 2. First frame writes everything, ascending, data = addr
    run_frame("first_frame", 1'b0);

    // 3. Unchanged RAM: no writes, short frame
    model_frame(1'b0, nexp);
    w0 = writes; d0 = done_cnt;
    pulse_frame(1'b0);
    start = cyc;
    wait_done(d0 + 1, 200);
    chk("nochange_writes", writes - w0, 0);
    chk("nochange_expected", nexp, 0);
    chk("nochange_len", (done_cyc - start >= 70) && (done_cyc - start <= 80), 1'b1);

    // 4. Two changed registers
    ram[4] = 8'hAA; ram[24] = 8'h55;
    run_frame("two_changes", 1'b0);

    // Randomized RAM updates
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NREG; i++)
        if ($urandom_range(0, 3) == 0) ram[i] = 8'($urandom_range(0, 255));
      run_frame("random_frame", 1'b0);
    end
    chk("no_overrun_yet", ovr_cnt, 0);

    // 5. Forced frame plus two requests while busy -> one merged extra frame
    model_frame(1'b1, nexp);
    model_frame(1'b0, nexp2);
    w0 = writes; d0 = done_cnt;
    pulse_frame(1'b1);
    repeat (100) @(posedge clk);
    pulse_frame(1'b0);
    repeat ($urandom_range(50, 200)) @(posedge clk);
    pulse_frame(1'b0);
    wait_done(d0 + 2, 3000);
    chk("force_writes", writes - w0, nexp + nexp2);
    chk("force_count", nexp, 25);
    chk("overrun_pulses", ovr_cnt, 1);
    chk("merged_frames", done_cnt - d0, 2);
    chk("force_queue_empty", exp_q.size(), 0);

    // 6. Reset mid-write at register 10
    model_frame(1'b1, nexp);
    pulse_frame(1'b1);
    ok = 0;
    for (int k = 0; k < 2000 && ok == 0; k++) begin
      @(posedge clk); #1;
      if (sid_cs === 1'b0 && sid_addr === 5'd10) ok = 1;
    end
    chk("reached_reg10", ok, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_cs", sid_cs, 1'b1);
    chk("abort_sid_rst", sid_rst, 1'b0);
    chk("abort_rw", sid_rw, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    // Request during the reset sequence stays pending until IDLE
    repeat (50) @(posedge clk);
    model_frame(1'b0, nexp);
    w0 = writes; d0 = done_cnt;
    pulse_frame(1'b0);
    chk("pending_in_reset_sid_rst", sid_rst, 1'b0);
    wait_done(d0 + 1, 3000);
    chk("post_reset_writes", writes - w0, 25);
    chk("post_reset_expected", nexp, 25);
    chk("post_reset_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
